calc_sequencer: RTL

CALC_SEQUENCER -- requirements
Module: calc_sequencer

---
 rtl/calc_sequencer.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/calc_sequencer.sv
// Key-driven calculator sequencer: collects operand A, an op code and operand B, starts the ALU
// and waits for its result. Optional key debounce is enabled by defining CALC_DEBOUNCE_EN.
module calc_sequencer #(
  parameter int unsigned TIMEOUT         = 255,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic       CLOCK_50,
  input  logic       RST_N,
  input  logic [3:0] KEY,
  input  logic [3:0] SW,
  input  logic       DONE,
  input  logic       OVF,
  output logic [3:0] OP,
  output logic [3:0] A,
  output logic [3:0] B,
  output logic       START,
  output logic       BUSY,
  output logic       ERR,
  output logic [2:0] STATE
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StOpsel = 3'd1,
    StEntb  = 3'd2,
    StExec  = 3'd3,
    StWait  = 3'd4,
    StShow  = 3'd5
  } state_e;

  localparam logic [8:0] TimeoutCmp = 9'(TIMEOUT);

  logic [3:0] sync1_q, sync2_q;
  logic [3:0] lvl_prev_q;
  logic [3:0] armed_q;
  logic [1:0] vld_q;
  logic [3:0] key_lvl;
  logic [3:0] press;

  // A key is armed only once it has been seen released after reset, so a key held
  // through reset release never produces a press.
  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      lvl_prev_q <= '0;
      armed_q    <= '0;
      vld_q      <= '0;
    end else begin
      sync1_q    <= KEY;
      sync2_q    <= sync1_q;
      vld_q      <= {vld_q[0], 1'b1};
      lvl_prev_q <= key_lvl;
      armed_q    <= armed_q | (~sync2_q & {4{vld_q[1]}});
    end
  end

`ifdef CALC_DEBOUNCE_EN
  localparam int unsigned DebW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DebW-1:0] DebMax = DebW'(DEBOUNCE_CYCLES);

  logic [DebW-1:0] deb_cnt_q [4];

  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < 4; i++) deb_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (!sync2_q[i]) begin
          deb_cnt_q[i] <= '0;
        end else if (deb_cnt_q[i] != DebMax) begin
          deb_cnt_q[i] <= deb_cnt_q[i] + DebW'(1);
        end
      end
    end
  end

  always_comb begin
    key_lvl = '0;
    for (int i = 0; i < 4; i++) key_lvl[i] = (deb_cnt_q[i] == DebMax);
  end
`else
  assign key_lvl = sync2_q;
`endif

  assign press = key_lvl & ~lvl_prev_q & armed_q;

  state_e     state_q, state_d;
  logic [3:0] a_q, a_d, b_q, b_d, op_q, op_d;
  logic       err_q, err_d;
  logic [7:0] cnt_q, cnt_d;
  logic       enter, op_press;
  logic [3:0] op_code;

  assign enter    = press[0];
  assign op_press = |press[3:1];
  assign op_code  = press[3] ? 4'b1010 : (press[2] ? 4'b1011 : 4'b1100);

  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (enter) begin
          a_d     = SW;
          state_d = StOpsel;
        end
      end
      StOpsel: begin
        if (op_press) begin
          op_d    = op_code;
          state_d = StEntb;
        end
      end
      StEntb: begin
        if (op_press) op_d = op_code;
        if (enter) begin
          b_d     = SW;
          state_d = StExec;
        end
      end
      StExec: begin
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        // DONE takes precedence over a coincident timeout
        if (DONE) begin
          err_d   = OVF;
          state_d = StShow;
        end else if (({1'b0, cnt_q} + 9'd1) == TimeoutCmp) begin
          err_d   = 1'b1;
          state_d = StShow;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StShow: begin
        if (enter) begin
          a_d     = '0;
          b_d     = '0;
          op_d    = '0;
          err_d   = 1'b0;
          state_d = StIdle;
        end else if (op_press) begin
          op_d    = op_code;
          err_d   = 1'b0;
          state_d = StExec;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign OP    = op_q;
  assign A     = a_q;
  assign B     = b_q;
  assign ERR   = err_q;
  assign START = (state_q == StExec);
  assign BUSY  = (state_q == StExec) || (state_q == StWait);
  assign STATE = state_q;

endmodule
